// File: rtl/dpp_table_pkg.sv
// Shared helpers for the dining-philosophers fork table: ring-index arithmetic
// used by the table and its round-robin arbiter.
package dpp_table_pkg;

    // Fork i is philosopher i's left fork; fork (i+1)%n is its right fork.
    function automatic int right_fork(input int i, input int n);
        return (i + 1) % n;
    endfunction

    // Philosopher whose right fork is fork j, i.e. the other user of fork j.
    function automatic int left_neighbour(input int j, input int n);
        return (j + n - 1) % n;
    endfunction

    // Ring position k steps after ptr.
    function automatic int ring_step(input int ptr, input int k, input int n);
        return (ptr + k) % n;
    endfunction

endpackage

// File: rtl/dpp_table_rr_arbiter.sv
// Combinational round-robin finder: first set bit of req scanning upward from
// ptr with wraparound. The table registers the result.
module dpp_table_rr_arbiter
    import dpp_table_pkg::*;
#(
    parameter int N     = 5,
    parameter int PTR_W = 3
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic             gnt_valid,
    output logic [PTR_W-1:0] gnt_idx
);

    always_comb begin
        // NOTE: every output gets a default before the scan so no path through
        // the loop leaves a value unassigned, which would otherwise infer a latch.
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < N; k++) begin
            if (!gnt_valid && req[ring_step(int'(ptr), k, N)]) begin
                gnt_valid = 1'b1;
                gnt_idx   = PTR_W'(ring_step(int'(ptr), k, N));
            end
        end
    end

endmodule

// File: rtl/dpp_table.sv
// Fork table for the dining-philosophers demo: grants at most one hungry
// philosopher per cycle, round-robin, when both of its forks are free.
module dpp_table
    import dpp_table_pkg::*;
#(
    parameter int N_PHILO      = 5,
    parameter int PTR_W        = 3,
    parameter int STARVE_LIMIT = 15,
    parameter int STARVE_W     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_PHILO-1:0] hungry,
    input  logic [N_PHILO-1:0] done,
    output logic [N_PHILO-1:0] eat_sig,
    output logic [N_PHILO-1:0] eating,
    output logic [N_PHILO-1:0] fork_busy,
    output logic [N_PHILO-1:0] starve,
    output logic               err
);

    logic [PTR_W-1:0]    rr_ptr;
    logic [PTR_W-1:0]    rr_ptr_next;
    logic [STARVE_W-1:0] wait_cnt [N_PHILO];

    logic [N_PHILO-1:0]  req;
    logic [N_PHILO-1:0]  gnt_onehot;
    logic [N_PHILO-1:0]  done_ok;
    logic [N_PHILO-1:0]  eating_next;
    logic [N_PHILO-1:0]  fork_next;
    logic                gnt_valid;
    logic [PTR_W-1:0]    gnt_idx;

    dpp_table_rr_arbiter #(
        .N     (N_PHILO),
        .PTR_W (PTR_W)
    ) u_arb (
        .req       (req),
        .ptr       (rr_ptr),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // Candidates look only at registered forks, so forks freed by a done this
    // edge cannot be re-granted until the next edge.
    always_comb begin
        req         = '0;
        gnt_onehot  = '0;
        fork_next   = '0;
        done_ok     = done & eating;
        rr_ptr_next = rr_ptr;
        for (int i = 0; i < N_PHILO; i++) begin
            req[i] = hungry[i] & ~eating[i] & ~fork_busy[i]
                   & ~fork_busy[right_fork(i, N_PHILO)];
            gnt_onehot[i] = gnt_valid && (gnt_idx == PTR_W'(i));
        end
        eating_next = (eating & ~done_ok) | gnt_onehot;
        for (int j = 0; j < N_PHILO; j++) begin
            fork_next[j] = eating_next[j] | eating_next[left_neighbour(j, N_PHILO)];
        end
        if (gnt_valid) begin
            rr_ptr_next = (gnt_idx == PTR_W'(N_PHILO - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            eat_sig   <= '0;
            eating    <= '0;
            fork_busy <= '0;
            starve    <= '0;
            err       <= 1'b0;
            rr_ptr    <= '0;
            // NOTE: the wait-counter array is ordinary flops, not RAM, so it is
            // reset element by element like any other state.
            for (int i = 0; i < N_PHILO; i++) begin
                wait_cnt[i] <= '0;
            end
        end else begin
            eat_sig   <= gnt_onehot;
            eating    <= eating_next;
            fork_busy <= fork_next;
            rr_ptr    <= rr_ptr_next;
            if (|(done & ~eating)) begin
                err <= 1'b1;
            end
            for (int i = 0; i < N_PHILO; i++) begin
                if (!hungry[i] || gnt_onehot[i]) begin
                    wait_cnt[i] <= '0;
                end else if (wait_cnt[i] != '1) begin
                    wait_cnt[i] <= wait_cnt[i] + 1'b1;
                end
                if (wait_cnt[i] == STARVE_W'(STARVE_LIMIT)) begin
                    starve[i] <= 1'b1;
                end
            end
        end
    end

    // Neighbours never eat together, and the fork map always follows eating.
    for (genvar i = 0; i < N_PHILO; i++) begin : g_inv
        assert property (@(posedge clk) disable iff (!reset)
            !(eating[i] && eating[(i + 1) % N_PHILO]));
        assert property (@(posedge clk) disable iff (!reset)
            fork_busy[i] == (eating[i] | eating[(i + N_PHILO - 1) % N_PHILO]));
    end

endmodule

// File: tb/tb_dpp_table.sv
// Directed bench for dpp_table: a step table for the single-grant protocol plus
// hand sequences for all-hungry contention, async reset and starvation.
module tb_dpp_table;

    localparam int N = 5;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] hungry;
    logic [N-1:0] done;
    logic [N-1:0] eat_sig;
    logic [N-1:0] eating;
    logic [N-1:0] fork_busy;
    logic [N-1:0] starve;
    logic         err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [N-1:0] hungry;
        logic [N-1:0] done;
        logic [N-1:0] eat_sig;
        logic [N-1:0] eating;
        logic [N-1:0] fork_busy;
        logic         err;
    } vec_t;

    vec_t vecs [17];

    always #5 clk = ~clk;

    dpp_table #(
        .N_PHILO      (5),
        .PTR_W        (3),
        .STARVE_LIMIT (15),
        .STARVE_W     (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .hungry    (hungry),
        .done      (done),
        .eat_sig   (eat_sig),
        .eating    (eating),
        .fork_busy (fork_busy),
        .starve    (starve),
        .err       (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act[N-1:0], exp[N-1:0]);
        end
    endtask

    // Advance one edge; outputs are sampled and inputs changed 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset  = 1'b0;
        hungry = '0;
        done   = '0;
        #3;
        reset = 1'b1;
        check("reset_eat_sig", 32'(eat_sig), 32'h0);
        check("reset_eating", 32'(eating), 32'h0);
        check("reset_fork_busy", 32'(fork_busy), 32'h0);
        check("reset_starve", 32'(starve), 32'h0);
        check("reset_err", 32'(err), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        //          hungry    done      eat_sig   eating    fork_busy err
        vecs[0]  = '{5'b00001, 5'b00000, 5'b00001, 5'b00001, 5'b00011, 1'b0};
        vecs[1]  = '{5'b00000, 5'b00000, 5'b00000, 5'b00001, 5'b00011, 1'b0};
        vecs[2]  = '{5'b00000, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 1'b0};
        vecs[3]  = '{5'b00001, 5'b00000, 5'b00001, 5'b00001, 5'b00011, 1'b0};
        vecs[4]  = '{5'b00010, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 1'b0};
        vecs[5]  = '{5'b00010, 5'b00000, 5'b00010, 5'b00010, 5'b00110, 1'b0};
        vecs[6]  = '{5'b00000, 5'b00010, 5'b00000, 5'b00000, 5'b00000, 1'b0};
        vecs[7]  = '{5'b00000, 5'b01000, 5'b00000, 5'b00000, 5'b00000, 1'b1};
        vecs[8]  = '{5'b00100, 5'b00000, 5'b00100, 5'b00100, 5'b01100, 1'b1};
        vecs[9]  = '{5'b00001, 5'b00100, 5'b00001, 5'b00001, 5'b00011, 1'b1};
        vecs[10] = '{5'b00000, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 1'b1};
        vecs[11] = '{5'b10000, 5'b00000, 5'b10000, 5'b10000, 5'b10001, 1'b1};
        vecs[12] = '{5'b00011, 5'b00000, 5'b00010, 5'b10010, 5'b10111, 1'b1};
        vecs[13] = '{5'b00001, 5'b00000, 5'b00000, 5'b10010, 5'b10111, 1'b1};
        vecs[14] = '{5'b00001, 5'b10010, 5'b00000, 5'b00000, 5'b00000, 1'b1};
        vecs[15] = '{5'b00001, 5'b00000, 5'b00001, 5'b00001, 5'b00011, 1'b1};
        vecs[16] = '{5'b00000, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 1'b1};

        @(posedge clk);
        #1;
        do_reset();

        for (int v = 0; v < 17; v++) begin
            hungry = vecs[v].hungry;
            done   = vecs[v].done;
            step();
            check($sformatf("v%0d_eat_sig", v), 32'(eat_sig), 32'(vecs[v].eat_sig));
            check($sformatf("v%0d_eating", v), 32'(eating), 32'(vecs[v].eating));
            check($sformatf("v%0d_fork_busy", v), 32'(fork_busy), 32'(vecs[v].fork_busy));
            check($sformatf("v%0d_err", v), 32'(err), 32'(vecs[v].err));
        end
        done = '0;
        check("table_starve", 32'(starve), 32'h0);

        // All philosophers hungry from reset: 0, then 2, then nobody.
        do_reset();
        hungry = 5'b11111;
        step();
        check("all_g0_eat_sig", 32'(eat_sig), 32'b00001);
        step();
        check("all_g2_eat_sig", 32'(eat_sig), 32'b00100);
        check("all_g2_eating", 32'(eating), 32'b00101);
        step();
        check("all_none_eat_sig", 32'(eat_sig), 32'b00000);
        check("all_none_eating", 32'(eating), 32'b00101);
        check("all_none_fork_busy", 32'(fork_busy), 32'b01111);

        // Asynchronous reset between edges while 0 and 2 are eating.
        #2;
        reset = 1'b0;
        #1;
        check("async_eating", 32'(eating), 32'h0);
        check("async_fork_busy", 32'(fork_busy), 32'h0);
        check("async_eat_sig", 32'(eat_sig), 32'h0);
        reset = 1'b1;
        step();
        check("post_reset_grant0", 32'(eat_sig), 32'b00001);

        // Starvation: philo 1 blocked by philo 0 holding fork 1.
        do_reset();
        hungry = 5'b00001;
        step();
        hungry = 5'b00010;
        for (int c = 1; c <= 15; c++) begin
            step();
        end
        check("starve_before_limit", 32'(starve), 32'b00000);
        step();
        check("starve_at_limit", 32'(starve), 32'b00010);
        done = 5'b00001;
        step();
        done = '0;
        check("starve_release_no_grant", 32'(eat_sig), 32'b00000);
        step();
        check("starve_late_grant", 32'(eat_sig), 32'b00010);
        hungry = '0;
        step();
        check("starve_sticky", 32'(starve), 32'b00010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
